// File: rtl/jk_seq_pkg.sv
// Shared types for the J-K command sequencer: op and state encodings, checker
// model record and its single-step update.
package jk_seq_pkg;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    typedef struct packed {
        logic model;
        logic known;
    } chk_t;

    localparam int unsigned ERR_MAX = 255;

    // One flip-flop clock of the model; hold and toggle never make Q known.
    function automatic chk_t chk_step(input chk_t cur, input op_e op);
        chk_t nxt;
        nxt = cur;
        case (op)
            OP_RESET:  nxt = '{model: 1'b0, known: 1'b1};
            OP_SET:    nxt = '{model: 1'b1, known: 1'b1};
            OP_TOGGLE: nxt.model = ~cur.model;
            default:   ;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit for full/empty.
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // NOTE: state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Replays buffered J/K commands for cmd_rep+1 cycles each. Define
// JK_SEQ_CHECK_EN to build the flip-flop model and Q compare.
module jk_cmd_sequencer
    import jk_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_rep,
    output logic             J,
    output logic             K,
    input  logic             q_in,
    output logic             busy,
    output logic             exp_q,
    output logic             mismatch,
    output logic [7:0]       err_count
);
    localparam int FW = 2 + CNT_W;

    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [FW-1:0]    fifo_head;
    op_e              head_op;
    logic [CNT_W-1:0] head_rep;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_e              jk_q, jk_d;

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    assign head_op   = op_e'(fifo_head[FW-1 -: 2]);
    assign head_rep  = fifo_head[CNT_W-1:0];

    jk_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(FW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata ({cmd_op, cmd_rep}),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .rdata (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            jk_q    <= OP_HOLD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            jk_q    <= jk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
            ST_ISSUE: if (cnt_q == '0 && fifo_empty) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // A finished command hands over to the next FIFO head on the same edge.
    always_comb begin
        fifo_pop = 1'b0;
        cnt_d    = cnt_q;
        jk_d     = jk_q;
        case (state_q)
            ST_IDLE: begin
                jk_d = OP_HOLD;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cnt_d    = head_rep;
                    jk_d     = head_op;
                end
            end
            ST_ISSUE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cnt_d    = head_rep;
                    jk_d     = head_op;
                end else begin
                    jk_d = OP_HOLD;
                end
            end
            default: jk_d = OP_HOLD;
        endcase
    end

    assign J    = jk_q[1];
    assign K    = jk_q[0];
    assign busy = (state_q != ST_IDLE) || !fifo_empty;

`ifdef JK_SEQ_CHECK_EN
    chk_t       cur_q, cur_d;
    chk_t       dly_q [LAT];
    chk_t       dly_d [LAT];
    logic       mismatch_q, mismatch_d;
    logic [7:0] err_q, err_d;
    logic       chk_fail;

    // The delay line is fed with the post-edge model so its tail lines up with q_in.
    always_comb begin
        cur_d    = chk_step(cur_q, jk_q);
        dly_d[0] = cur_d;
        for (int i = 1; i < LAT; i++) dly_d[i] = dly_q[i-1];
        chk_fail   = dly_q[LAT-1].known && (q_in != dly_q[LAT-1].model);
        mismatch_d = mismatch_q || chk_fail;
        err_d      = err_q;
        if (chk_fail && err_q != 8'(ERR_MAX)) err_d = err_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_q      <= '0;
            dly_q      <= '{default: '0};
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else begin
            cur_q      <= cur_d;
            dly_q      <= dly_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
        end
    end

    assign exp_q     = dly_q[LAT-1].model;
    assign mismatch  = mismatch_q;
    assign err_count = err_q;
`else
    logic unused_q_in;
    localparam int unused_lat = LAT;

    assign unused_q_in = q_in;
    assign exp_q       = 1'b0;
    assign mismatch    = 1'b0;
    assign err_count   = '0;
`endif

endmodule
